// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the CPU/DMA bus arbiter.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    DMA_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DMA = 1'b1
  } master_e;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts granted cycles without ack; expired goes high once LIMIT cycles have elapsed.
module bus_timeout_counter
  import dma_arb_pkg::*;
#(
  parameter int LIMIT = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Every transfer ends by returning to IDLE, so holding zero there clears it on entry to BUSY.
  always_comb begin
    count_d = count_q;
    if (!busy) begin
      count_d = '0;
    end else if (!ack && !expired) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = busy && (count_q == LIMIT_C);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Two-master (CPU/DMA) round-robin arbiter onto one downstream bus.
// Optional forced completion on missing ack: CONFIG_DMA_ARB_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no grant, downstream outputs all zero
// CPU_BUSY | CPU owns the bus until ack (or timeout)
// DMA_BUSY | DMA owns the bus until ack (or timeout)
module dma_bus_arbiter
  import dma_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [19:1] cpu_m_addr,
  input  logic [15:0] cpu_m_data_out,
  input  logic        cpu_m_access,
  input  logic        cpu_m_wr_en,
  input  logic [1:0]  cpu_m_bytesel,
  output logic [15:0] cpu_m_data_in,
  output logic        cpu_m_ack,

  input  logic [19:1] dma_m_addr,
  input  logic [15:0] dma_m_data_out,
  input  logic        dma_m_access,
  input  logic        dma_m_wr_en,
  input  logic [1:0]  dma_m_bytesel,
  output logic [15:0] dma_m_data_in,
  output logic        dma_m_ack,

  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic [15:0] q_m_data_in,
  input  logic        q_m_ack,

  output logic        bus_error
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dma_bus_arbiter: TIMEOUT_CYCLES must be within 1..255");
  end

  arb_state_e state_q, state_d;
  master_e    last_grant_q, last_grant_d;
  logic       timeout_hit;
  logic       xfer_done;

`ifdef CONFIG_DMA_ARB_TIMEOUT_EN
  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .busy    (state_q != IDLE),
    .ack     (q_m_ack),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign xfer_done = q_m_ack || timeout_hit;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (cpu_m_access && (!dma_m_access || last_grant_q == MST_DMA)) begin
          state_d      = CPU_BUSY;
          last_grant_d = MST_CPU;
        end else if (dma_m_access) begin
          state_d      = DMA_BUSY;
          last_grant_d = MST_DMA;
        end
      end
      CPU_BUSY, DMA_BUSY: begin
        if (xfer_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= MST_DMA;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // A real ack in the expiry cycle wins over the forced completion.
  always_comb begin
    q_m_addr      = '0;
    q_m_data_out  = '0;
    q_m_access    = 1'b0;
    q_m_wr_en     = 1'b0;
    q_m_bytesel   = '0;
    cpu_m_data_in = '0;
    cpu_m_ack     = 1'b0;
    dma_m_data_in = '0;
    dma_m_ack     = 1'b0;
    bus_error     = 1'b0;
    case (state_q)
      CPU_BUSY: begin
        q_m_access   = 1'b1;
        q_m_addr     = cpu_m_addr;
        q_m_data_out = cpu_m_data_out;
        q_m_wr_en    = cpu_m_wr_en;
        q_m_bytesel  = cpu_m_bytesel;
        if (q_m_ack) begin
          cpu_m_ack     = 1'b1;
          cpu_m_data_in = q_m_data_in;
        end else if (timeout_hit) begin
          cpu_m_ack     = 1'b1;
          cpu_m_data_in = 16'hFFFF;
          bus_error     = 1'b1;
        end
      end
      DMA_BUSY: begin
        q_m_access   = 1'b1;
        q_m_addr     = dma_m_addr;
        q_m_data_out = dma_m_data_out;
        q_m_wr_en    = dma_m_wr_en;
        q_m_bytesel  = dma_m_bytesel;
        if (q_m_ack) begin
          dma_m_ack     = 1'b1;
          dma_m_data_in = q_m_data_in;
        end else if (timeout_hit) begin
          dma_m_ack     = 1'b1;
          dma_m_data_in = 16'hFFFF;
          bus_error     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: directed transfers, expected master responses queued.
module tb_dma_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic [19:1] cpu_m_addr, dma_m_addr, q_m_addr;
  logic [15:0] cpu_m_data_out, dma_m_data_out, q_m_data_out;
  logic        cpu_m_access, dma_m_access, q_m_access;
  logic        cpu_m_wr_en, dma_m_wr_en, q_m_wr_en;
  logic [1:0]  cpu_m_bytesel, dma_m_bytesel, q_m_bytesel;
  logic [15:0] cpu_m_data_in, dma_m_data_in, q_m_data_in;
  logic        cpu_m_ack, dma_m_ack, q_m_ack;
  logic        bus_error;

  dma_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_m_addr(cpu_m_addr), .cpu_m_data_out(cpu_m_data_out), .cpu_m_access(cpu_m_access),
    .cpu_m_wr_en(cpu_m_wr_en), .cpu_m_bytesel(cpu_m_bytesel),
    .cpu_m_data_in(cpu_m_data_in), .cpu_m_ack(cpu_m_ack),
    .dma_m_addr(dma_m_addr), .dma_m_data_out(dma_m_data_out), .dma_m_access(dma_m_access),
    .dma_m_wr_en(dma_m_wr_en), .dma_m_bytesel(dma_m_bytesel),
    .dma_m_data_in(dma_m_data_in), .dma_m_ack(dma_m_ack),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
    .q_m_data_in(q_m_data_in), .q_m_ack(q_m_ack),
    .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        dma;
    logic [15:0] data;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic dma, input logic [15:0] data, input logic berr);
    exp_t e;
    e.dma  = dma;
    e.data = data;
    e.berr = berr;
    sb.push_back(e);
  endtask

  // Monitor: every master response is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (cpu_m_ack || dma_m_ack || bus_error) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: cpu_ack=%0b dma_ack=%0b bus_error=%0b, expected none",
                   cpu_m_ack, dma_m_ack, bus_error);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_select", {30'd0, cpu_m_ack, dma_m_ack}, e.dma ? 32'd1 : 32'd2);
          chk("ack_data", e.dma ? dma_m_data_in : cpu_m_data_in, e.data);
          chk("bus_error", bus_error, e.berr);
        end
      end
      if (!cpu_m_ack) chk("cpu_data_idle", cpu_m_data_in, 0);
      if (!dma_m_ack) chk("dma_data_idle", dma_m_data_in, 0);
    end
  end

  initial begin
    reset_n = 1'b0;
    cpu_m_addr = '0; cpu_m_data_out = '0; cpu_m_access = 0; cpu_m_wr_en = 0; cpu_m_bytesel = '0;
    dma_m_addr = '0; dma_m_data_out = '0; dma_m_access = 0; dma_m_wr_en = 0; dma_m_bytesel = '0;
    q_m_data_in = '0; q_m_ack = 0;

    // Reset state, even with requests and ack present
    cpu_m_access = 1; dma_m_access = 1; q_m_ack = 1; q_m_data_in = 16'hAAAA;
    tick();
    @(negedge clk);
    chk("rst_outputs", {q_m_access, q_m_wr_en, cpu_m_ack, dma_m_ack, bus_error}, 0);
    chk("rst_q_addr", q_m_addr, 0);
    tick();
    cpu_m_access = 0; dma_m_access = 0;
    reset_n = 1;

    // Ack while idle is ignored
    @(negedge clk);
    chk("idle_ack_ignored", {cpu_m_ack, dma_m_ack}, 0);
    tick();
    q_m_ack = 0; q_m_data_in = '0;
    @(negedge clk);
    chk("idle_stays", q_m_access, 0);

    // CPU read, ack three cycles after grant
    tick();
    cpu_m_addr = 19'h00100; cpu_m_wr_en = 0; cpu_m_access = 1;
    @(negedge clk);
    chk("cpu_rd_lat_n", q_m_access, 0);
    tick();
    @(negedge clk);
    chk("cpu_rd_access", q_m_access, 1);
    chk("cpu_rd_addr", q_m_addr, 32'h00100);
    chk("cpu_rd_wr_en", q_m_wr_en, 0);
    tick();
    tick();
    q_m_ack = 1; q_m_data_in = 16'h1234;
    expect_resp(1'b0, 16'h1234, 1'b0);
    @(negedge clk);
    chk("cpu_rd_dma_ack", dma_m_ack, 0);
    tick();
    q_m_ack = 0; q_m_data_in = '0; cpu_m_access = 0;
    @(negedge clk);
    chk("cpu_rd_done", q_m_access, 0);

    // Tie after reset: CPU, one idle cycle, DMA, then next tie to CPU
    reset_n = 0;
    tick();
    reset_n = 1;
    cpu_m_addr = 19'h00200; dma_m_addr = 19'h00300;
    cpu_m_access = 1; dma_m_access = 1;
    @(negedge clk);
    chk("tie_idle", q_m_access, 0);
    tick();
    q_m_ack = 1; q_m_data_in = 16'h0001;
    expect_resp(1'b0, 16'h0001, 1'b0);
    @(negedge clk);
    chk("tie1_addr_cpu", q_m_addr, 32'h00200);
    tick();
    q_m_ack = 0; q_m_data_in = '0; cpu_m_access = 0;
    @(negedge clk);
    chk("tie_gap_idle", q_m_access, 0);
    tick();
    q_m_ack = 1; q_m_data_in = 16'h0002;
    expect_resp(1'b1, 16'h0002, 1'b0);
    @(negedge clk);
    chk("tie2_access", q_m_access, 1);
    chk("tie2_addr_dma", q_m_addr, 32'h00300);
    tick();
    q_m_ack = 0; q_m_data_in = '0;
    cpu_m_access = 1;
    @(negedge clk);
    chk("tie3_idle", q_m_access, 0);
    tick();
    q_m_ack = 1; q_m_data_in = 16'h0003;
    expect_resp(1'b0, 16'h0003, 1'b0);
    @(negedge clk);
    chk("tie3_addr_cpu", q_m_addr, 32'h00200);
    tick();
    q_m_ack = 0; q_m_data_in = '0; cpu_m_access = 0; dma_m_access = 0;

    // DMA write held until ack, master drops access mid-transfer
    tick();
    dma_m_addr = 19'h7ABCD; dma_m_data_out = 16'hBEEF; dma_m_wr_en = 1;
    dma_m_bytesel = 2'b01; dma_m_access = 1;
    tick();
    dma_m_access = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dma_wr_access", q_m_access, 1);
      chk("dma_wr_data", q_m_data_out, 32'hBEEF);
      chk("dma_wr_ctl", {q_m_wr_en, q_m_bytesel}, 32'b101);
      chk("dma_wr_addr", q_m_addr, 32'h7ABCD);
      tick();
    end
    q_m_ack = 1; q_m_data_in = 16'h5555;
    expect_resp(1'b1, 16'h5555, 1'b0);
    @(negedge clk);
    tick();
    q_m_ack = 0; q_m_data_in = '0; dma_m_wr_en = 0; dma_m_bytesel = '0; dma_m_data_out = '0;
    @(negedge clk);
    chk("dma_wr_done", {q_m_access, q_m_wr_en, q_m_bytesel}, 0);

    // Reset in the middle of a DMA transfer
    tick();
    dma_m_access = 1;
    tick();
    @(negedge clk);
    chk("rst_mid_busy", q_m_access, 1);
    #1 reset_n = 0;
    #1 chk("rst_mid_async", {q_m_access, q_m_wr_en, q_m_addr}, 0);
    tick();
    dma_m_access = 0;
    tick();
    reset_n = 1;
    cpu_m_addr = 19'h00440; cpu_m_access = 1;
    @(negedge clk);
    chk("rst_rel_lat_n", q_m_access, 0);
    tick();
    q_m_ack = 1; q_m_data_in = 16'h0440;
    expect_resp(1'b0, 16'h0440, 1'b0);
    @(negedge clk);
    chk("rst_rel_access", q_m_access, 1);
    chk("rst_rel_addr", q_m_addr, 32'h00440);
    tick();
    q_m_ack = 0; q_m_data_in = '0; cpu_m_access = 0;

    // Missing ack
    tick();
    cpu_m_addr = 19'h00555; cpu_m_access = 1;
    tick();
    cpu_m_access = 0;
`ifdef CONFIG_DMA_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_wait_access", q_m_access, 1);
      tick();
    end
    expect_resp(1'b0, 16'hFFFF, 1'b1);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("to_released", q_m_access, 0);
`else
    begin
      int dropped;
      dropped = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (q_m_access !== 1'b1 || bus_error !== 1'b0) dropped++;
      end
      chk("no_to_hold_1000", dropped, 0);
    end
    tick();
    q_m_ack = 1; q_m_data_in = 16'h0555;
    expect_resp(1'b0, 16'h0555, 1'b0);
    @(negedge clk);
    tick();
    q_m_ack = 0; q_m_data_in = '0;
    @(negedge clk);
    chk("no_to_released", q_m_access, 0);
`endif

    tick();
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
